// File: rtl/green_tracker_ctrl_if.sv
// rtl/green_tracker_ctrl_if.sv - control, pixel and result signals of the green tracker
interface green_tracker_ctrl_if;
    logic        start;
    logic        cont;
    logic        vsync;
    logic        pix_valid;
    logic        eh_verde;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        result_ready;
    logic        det_en;
    logic        busy;
    logic        result_valid;
    logic        found;
    logic [18:0] count;
    logic [9:0]  x_min;
    logic [9:0]  x_max;
    logic [9:0]  y_min;
    logic [9:0]  y_max;

    modport master (
        output start, cont, vsync, pix_valid, eh_verde, x, y, result_ready,
        input  det_en, busy, result_valid, found, count, x_min, x_max, y_min, y_max
    );

    modport slave (
        input  start, cont, vsync, pix_valid, eh_verde, x, y, result_ready,
        output det_en, busy, result_valid, found, count, x_min, x_max, y_min, y_max
    );
endinterface

// File: rtl/green_tracker_ctrl.sv
// rtl/green_tracker_ctrl.sv - per-frame green pixel count and bounding box with result handshake
module green_tracker_ctrl #(
    parameter logic [18:0] MIN_PIXELS = 19'd64,
    parameter logic [9:0]  X_LIMIT    = 10'd640,
    parameter logic [9:0]  Y_LIMIT    = 10'd480
) (
    input  logic                  PCLK,
    input  logic                  reset,
    green_tracker_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_ACCUM   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [9:0]  bx_min_q, bx_min_d, bx_max_q, bx_max_d;
    logic [9:0]  by_min_q, by_min_d, by_max_q, by_max_d;
    logic        rv_q, rv_d;
    logic        found_q, found_d;
    logic [18:0] count_q, count_d;
    logic [9:0]  x_min_q, x_min_d, x_max_q, x_max_d;
    logic [9:0]  y_min_q, y_min_d, y_max_q, y_max_d;
    logic        qualify;

    // The closing vsync cycle never contributes a pixel.
    assign qualify = bus.pix_valid && bus.eh_verde && !bus.vsync
                  && (bus.x < X_LIMIT) && (bus.y < Y_LIMIT);

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bx_min_q <= 10'h3FF;
            bx_max_q <= '0;
            by_min_q <= 10'h3FF;
            by_max_q <= '0;
            rv_q     <= 1'b0;
            found_q  <= 1'b0;
            count_q  <= '0;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bx_min_q <= bx_min_d;
            bx_max_q <= bx_max_d;
            by_min_q <= by_min_d;
            by_max_q <= by_max_d;
            rv_q     <= rv_d;
            found_q  <= found_d;
            count_q  <= count_d;
            x_min_q  <= x_min_d;
            x_max_q  <= x_max_d;
            y_min_q  <= y_min_d;
            y_max_q  <= y_max_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bx_min_d = bx_min_q;
        bx_max_d = bx_max_q;
        by_min_d = by_min_q;
        by_max_d = by_max_q;
        rv_d     = rv_q;
        found_d  = found_q;
        count_d  = count_q;
        x_min_d  = x_min_q;
        x_max_d  = x_max_q;
        y_min_d  = y_min_q;
        y_max_d  = y_max_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (bus.vsync) begin
                    state_d  = S_ACCUM;
                    cnt_d    = '0;
                    bx_min_d = 10'h3FF;
                    bx_max_d = '0;
                    by_min_d = 10'h3FF;
                    by_max_d = '0;
                end
            end
            S_ACCUM: begin
                if (bus.vsync) begin
                    state_d = S_HOLD;
                    rv_d    = 1'b1;
                    count_d = cnt_q;
                    found_d = (cnt_q >= MIN_PIXELS);
                    // An empty frame reports a zero box rather than the clear sentinels.
                    x_min_d = (cnt_q != '0) ? bx_min_q : '0;
                    x_max_d = (cnt_q != '0) ? bx_max_q : '0;
                    y_min_d = (cnt_q != '0) ? by_min_q : '0;
                    y_max_d = (cnt_q != '0) ? by_max_q : '0;
                end else if (qualify) begin
                    cnt_d = (cnt_q == 19'h7FFFF) ? cnt_q : cnt_q + 19'd1;
                    if (bus.x < bx_min_q) bx_min_d = bus.x;
                    if (bus.x > bx_max_q) bx_max_d = bus.x;
                    if (bus.y < by_min_q) by_min_d = bus.y;
                    if (bus.y > by_max_q) by_max_d = bus.y;
                end
            end
            S_HOLD: begin
                if (bus.result_ready) begin
                    rv_d    = 1'b0;
                    state_d = bus.cont ? S_WAIT_VS : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.det_en       = (state_q == S_ACCUM);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = rv_q;
    assign bus.found        = found_q;
    assign bus.count        = count_q;
    assign bus.x_min        = x_min_q;
    assign bus.x_max        = x_max_q;
    assign bus.y_min        = y_min_q;
    assign bus.y_max        = y_max_q;
endmodule

// File: tb/tb_green_tracker_ctrl.sv
// tb/tb_green_tracker_ctrl.sv - directed self-checking bench for green_tracker_ctrl
module tb_green_tracker_ctrl;
    logic PCLK = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    green_tracker_ctrl_if gif ();

    green_tracker_ctrl #(
        .MIN_PIXELS (19'd64),
        .X_LIMIT    (10'd640),
        .Y_LIMIT    (10'd480)
    ) dut (
        .PCLK  (PCLK),
        .reset (reset),
        .bus   (gif.slave)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic busy, input logic det_en);
        chk({tag, ".busy"},   32'(gif.busy),   32'(busy));
        chk({tag, ".det_en"}, 32'(gif.det_en), 32'(det_en));
    endtask

    task automatic check_res(input string tag, input logic rv, input logic fnd,
                             input logic [18:0] cnt, input logic [9:0] xmn,
                             input logic [9:0] xmx, input logic [9:0] ymn,
                             input logic [9:0] ymx);
        chk({tag, ".result_valid"}, 32'(gif.result_valid), 32'(rv));
        chk({tag, ".found"},        32'(gif.found),        32'(fnd));
        chk({tag, ".count"},        32'(gif.count),        32'(cnt));
        chk({tag, ".x_min"},        32'(gif.x_min),        32'(xmn));
        chk({tag, ".x_max"},        32'(gif.x_max),        32'(xmx));
        chk({tag, ".y_min"},        32'(gif.y_min),        32'(ymn));
        chk({tag, ".y_max"},        32'(gif.y_max),        32'(ymx));
    endtask

    task automatic clear_in();
        gif.start = 1'b0;
        gif.vsync = 1'b0;
        gif.pix_valid = 1'b0;
        gif.eh_verde = 1'b0;
        gif.x = '0;
        gif.y = '0;
        gif.result_ready = 1'b0;
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic green);
        gif.pix_valid = 1'b1;
        gif.eh_verde = green;
        gif.x = px;
        gif.y = py;
        tick();
        gif.pix_valid = 1'b0;
        gif.eh_verde = 1'b0;
    endtask

    task automatic pulse_start();
        gif.start = 1'b1;
        tick();
        gif.start = 1'b0;
    endtask

    task automatic pulse_vsync();
        gif.vsync = 1'b1;
        tick();
        gif.vsync = 1'b0;
    endtask

    task automatic ack();
        gif.result_ready = 1'b1;
        tick();
        gif.result_ready = 1'b0;
    endtask

    initial begin
        clear_in();
        gif.cont = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_st("reset", 1'b0, 1'b0);
        check_res("reset", 1'b0, 1'b0, 19'd0, 10'd0, 10'd0, 10'd0, 10'd0);

        // Basic frame, with a stray start in ACCUM and a green pixel on the closing vsync
        pulse_start();
        check_st("f1_arm", 1'b1, 1'b0);
        pulse_vsync();
        check_st("f1_open", 1'b1, 1'b1);
        pix(10'd100, 10'd50, 1'b1);
        pix(10'd5, 10'd5, 1'b0);
        pix(10'd300, 10'd200, 1'b1);
        pulse_start();
        check_st("f1_start_ignored", 1'b1, 1'b1);
        pix(10'd120, 10'd400, 1'b1);
        gif.pix_valid = 1'b1;
        gif.eh_verde = 1'b1;
        gif.x = 10'd5;
        gif.y = 10'd5;
        pulse_vsync();
        clear_in();
        check_res("f1", 1'b1, 1'b0, 19'd3, 10'd100, 10'd300, 10'd50, 10'd400);
        check_st("f1_hold", 1'b1, 1'b0);
        ack();
        check_res("f1_ack", 1'b0, 1'b0, 19'd3, 10'd100, 10'd300, 10'd50, 10'd400);
        check_st("f1_idle", 1'b0, 1'b0);

        // Reset in the middle of accumulation
        pulse_start();
        pulse_vsync();
        for (int i = 0; i < 5; i++) pix(10'(200 + i), 10'(100 + i), 1'b1);
        reset = 1'b1;
        gif.pix_valid = 1'b1;
        gif.eh_verde = 1'b1;
        gif.start = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        check_st("rst_mid", 1'b0, 1'b0);
        check_res("rst_mid", 1'b0, 1'b0, 19'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        pulse_start();
        pulse_vsync();
        pulse_vsync();
        check_res("after_rst", 1'b1, 1'b0, 19'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        ack();

        // Threshold frame with out-of-range pixels
        pulse_start();
        pulse_vsync();
        for (int i = 0; i < 64; i++) pix(10'd10, 10'(10 + i), 1'b1);
        pix(10'd700, 10'd20, 1'b1);
        pix(10'd640, 10'd30, 1'b1);
        pix(10'd10, 10'd480, 1'b1);
        pix(10'd3, 10'd3, 1'b0);
        pulse_vsync();
        check_res("f2", 1'b1, 1'b1, 19'd64, 10'd10, 10'd10, 10'd10, 10'd73);

        // Backpressure with cont=1: vsync, pixels and start all ignored in HOLD
        gif.cont = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gif.vsync = (i % 3 == 0);
            gif.pix_valid = 1'b1;
            gif.eh_verde = 1'b1;
            gif.start = 1'b1;
            tick();
            check_res("bp", 1'b1, 1'b1, 19'd64, 10'd10, 10'd10, 10'd10, 10'd73);
            check_st("bp", 1'b1, 1'b0);
        end
        clear_in();
        ack();
        check_res("f2_ack", 1'b0, 1'b1, 19'd64, 10'd10, 10'd10, 10'd10, 10'd73);
        check_st("f2_rearm", 1'b1, 1'b0);
        gif.cont = 1'b0;

        // Empty frame entered straight from the re-armed WAIT_VS
        pulse_vsync();
        check_st("f3_open", 1'b1, 1'b1);
        pix(10'd50, 10'd60, 1'b0);
        pix(10'd800, 10'd100, 1'b1);
        pulse_vsync();
        check_res("f3", 1'b1, 1'b0, 19'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        ack();
        check_st("f3_idle", 1'b0, 1'b0);

        // result_ready and vsync while idle have no effect
        gif.result_ready = 1'b1;
        gif.vsync = 1'b1;
        tick();
        clear_in();
        check_st("idle_rr", 1'b0, 1'b0);
        chk("idle_rr.result_valid", 32'(gif.result_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
